// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions used by the receiver and the transmitter.
// Holds the FSM state encoding and the oversampling/framing constants.
// No ports; import with `import uart_pkg::*;`.
package uart_pkg;

  // Receiver/transmitter phase within a frame.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int OVS          = 16;  // oversample ticks per bit
  localparam int DATA_BITS    = 8;   // data bits per frame, LSB first
  localparam int START_SAMPLE = 8;   // tick index of mid start bit

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: restartable oversample tick generator (one tick every OVS_DIV clocks).
// Latency: first tick OVS_DIV cycles after restart; no backpressure, free-running otherwise.
// Ports: clk_in/rst (async high) clock+reset, restart zeroes the count, tick is high for one cycle.
module uart_baud_tick #(
  parameter int unsigned OVS_DIV = 27
) (
  input  logic clk_in,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(OVS_DIV - 1);

  logic [15:0] r_cnt;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Restart does not mask tick combinationally, so the FSM can use the tick
  // that ends a phase and request the restart for the next phase together.
  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampled, single clock domain.
// Latency: data_valid/frame_err pulse 2 + 152*OVS_DIV cycles after the start edge is seen.
// Backpressure: none; each byte is presented once with a one-cycle data_valid strobe.
// Ports: clk_in, rst (async high), rx_in (async serial line, idle high),
//        data_out (last good byte), data_valid, frame_err (one-cycle pulses), busy (not IDLE).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVS_DIV = 27
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [3:0] START_LAST = 4'(START_SAMPLE - 1);
  localparam logic [3:0] OVS_LAST   = 4'(OVS - 1);
  localparam logic [2:0] BIT_LAST   = 3'(DATA_BITS - 1);

  uart_state_e r_state;
  logic        r_sync1;
  logic        r_rx_s;
  logic        r_rx_d;
  logic [3:0]  r_sample;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ferr;

  logic w_tick;
  logic w_start_edge;
  logic w_restart;

  // Two-flop synchroniser plus one delay flop for edge detection. Reset to
  // the idle level so a reset never manufactures a start edge by itself.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;
    end
  end

  assign w_start_edge = r_rx_d & ~r_rx_s;

  // Realign the tick counter whenever a new phase (START, DATA, STOP) begins.
  always_comb begin
    w_restart = 1'b0;
    case (r_state)
      IDLE:  w_restart = w_start_edge;
      START: w_restart = w_tick && (r_sample == START_LAST) && !r_rx_s;
      DATA:  w_restart = w_tick && (r_sample == OVS_LAST) && (r_bit == BIT_LAST);
      default: w_restart = 1'b0;
    endcase
  end

  uart_baud_tick #(
    .OVS_DIV (OVS_DIV)
  ) u_baud_tick (
    .clk_in  (clk_in),
    .rst     (rst),
    .restart (w_restart),
    .tick    (w_tick)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sample <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_edge) begin
            r_state  <= START;
            r_sample <= '0;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_sample == START_LAST) begin
              r_sample <= '0;
              // A line that is high again by mid start bit was a glitch.
              if (!r_rx_s) begin
                r_state <= DATA;
                r_bit   <= '0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_sample <= r_sample + 4'd1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_sample == OVS_LAST) begin
              r_sample <= '0;
              r_shift  <= {r_rx_s, r_shift[7:1]};
              r_bit    <= r_bit + 3'd1;
              if (r_bit == BIT_LAST) begin
                r_state <= STOP;
              end
            end else begin
              r_sample <= r_sample + 4'd1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_sample == OVS_LAST) begin
              r_sample <= '0;
              r_state  <= IDLE;
              if (r_rx_s) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_ferr  <= 1'b1;
              end
            end else begin
              r_sample <= r_sample + 4'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_ferr;
  // Combinational from state so an async reset drops busy immediately.
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int D   = 4;            // OVS_DIV used for the bench
  localparam int BIT = 16 * D;       // nominal clocks per bit
  localparam int LAT = 3 + 152 * D;  // pin fall (negedge stamp) to pulse stamp

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.OVS_DIV(D)) dut (
    .clk_in     (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic [7:0]  dat;
    logic [31:0] at;
  } ev_t;

  typedef struct {
    logic [7:0] dat;
    logic       stopv;
    int         bc;
    logic       exp_vld;
    logic [7:0] exp_dat;
  } vec_t;

  ev_t        q_obs[$];
  ev_t        q_exp[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         last_fall = 0;
  logic [7:0] last_good = 8'h00;
  vec_t       vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse with the data_out seen alongside it.
  always @(negedge clk) begin
    if (data_valid || frame_err) begin
      ev_t e;
      n_cmp++;
      if (data_valid && frame_err) begin
        n_err++;
        $display("FAIL pulse_exclusive: data_valid and frame_err both high at cycle %0d", cyc);
      end
      e.is_err = frame_err;
      e.dat    = data_out;
      e.at     = 32'(cyc);
      q_obs.push_back(e);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, want);
    end
  endtask

  // Reference model: a frame with a high stop bit yields its byte; a low stop
  // bit yields a frame error with data_out still showing the last good byte.
  task automatic expect_frame(input logic [7:0] b, input logic stopv);
    ev_t e;
    if (stopv) last_good = b;
    e.is_err = ~stopv;
    e.dat    = last_good;
    e.at     = 32'(last_fall + LAT);
    q_exp.push_back(e);
  endtask

  task automatic check_events(input string nm);
    n_cmp++;
    if (q_obs.size() != q_exp.size()) begin
      n_err++;
      $display("FAIL %s event count: got %0d, expected %0d", nm, q_obs.size(), q_exp.size());
    end
    for (int i = 0; i < q_exp.size() && i < q_obs.size(); i++) begin
      n_cmp++;
      if (q_obs[i] !== q_exp[i]) begin
        n_err++;
        $display("FAIL %s event %0d: got err=%0b data=%02h cyc=%0d, expected err=%0b data=%02h cyc=%0d",
                 nm, i, q_obs[i].is_err, q_obs[i].dat, q_obs[i].at,
                 q_exp[i].is_err, q_exp[i].dat, q_exp[i].at);
      end
    end
    q_obs.delete();
    q_exp.delete();
  endtask

  // Drives one frame starting at the current negedge; leaves the line at stopv.
  task automatic send(input logic [7:0] b, input int bc, input logic stopv);
    last_fall = cyc;
    rx_in = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (bc) @(negedge clk);
    end
    rx_in = stopv;
    repeat (bc) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{dat: 8'hA5, stopv: 1'b1, bc: BIT,     exp_vld: 1'b1, exp_dat: 8'hA5};
    vecs[1] = '{dat: 8'hC3, stopv: 1'b1, bc: BIT + 2, exp_vld: 1'b1, exp_dat: 8'hC3};
    vecs[2] = '{dat: 8'h5A, stopv: 1'b1, bc: BIT,     exp_vld: 1'b1, exp_dat: 8'h5A};
    vecs[3] = '{dat: 8'hC3, stopv: 1'b1, bc: BIT - 2, exp_vld: 1'b1, exp_dat: 8'hC3};
    vecs[4] = '{dat: 8'h55, stopv: 1'b0, bc: BIT,     exp_vld: 1'b0, exp_dat: 8'hC3};
    vecs[5] = '{dat: 8'h81, stopv: 1'b1, bc: BIT,     exp_vld: 1'b1, exp_dat: 8'h81};

    rx_in = 1'b1;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data_out", 32'(data_out), 32'h00);
    chk("reset_data_valid", 32'(data_valid), 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(10);

    // Table: single frames, nominal and +/-3 % bit periods, one framing error.
    for (int v = 0; v < 6; v++) begin
      ev_t e;
      send(vecs[v].dat, vecs[v].bc, vecs[v].stopv);
      e.is_err = ~vecs[v].exp_vld;
      e.dat    = vecs[v].exp_dat;
      e.at     = 32'(last_fall + LAT);
      q_exp.push_back(e);
      last_good = vecs[v].exp_dat;
      idle(40);
      check_events($sformatf("vec%0d", v));
    end

    // Back-to-back frames with only the single stop bit between them.
    send(8'h00, BIT, 1'b1); expect_frame(8'h00, 1'b1);
    send(8'hFF, BIT, 1'b1); expect_frame(8'hFF, 1'b1);
    send(8'h3C, BIT, 1'b1); expect_frame(8'h3C, 1'b1);
    idle(40);
    check_events("back_to_back");

    // Framing error with the line held low for 3 bit times: must not re-arm.
    send(8'h55, BIT, 1'b0); expect_frame(8'h55, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    chk("ferr_no_rearm_busy", 32'(busy), 32'h0);
    idle(20);
    check_events("ferr_hold_low");
    chk("ferr_data_kept", 32'(data_out), 32'h3C);
    send(8'h81, BIT, 1'b1); expect_frame(8'h81, 1'b1);
    idle(40);
    check_events("after_ferr");

    // Glitch: 8-cycle low pulse. START entered 3 stamps after the fall and
    // abandoned at the mid-start sample 8 ticks (32 cycles) later.
    rx_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("glitch_busy_before", 32'(busy), 32'h0);
    @(negedge clk);
    chk("glitch_busy_rise", 32'(busy), 32'h1);
    repeat (5) @(negedge clk);
    rx_in = 1'b1;
    repeat (26) @(negedge clk);
    chk("glitch_busy_hold", 32'(busy), 32'h1);
    @(negedge clk);
    chk("glitch_busy_fall", 32'(busy), 32'h0);
    idle(700);
    check_events("glitch");

    // Reset during data bit 3 of 8'hB6, then a clean 8'h12 frame.
    rx_in = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_in = (8'hB6 >> i) & 8'h01;
      repeat (BIT) @(negedge clk);
    end
    rx_in = 1'b0;
    repeat (20) @(negedge clk);
    chk("midframe_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("reset_busy_immediate", 32'(busy), 32'h0);
    chk("reset_data_cleared", 32'(data_out), 32'h00);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    idle(700);
    check_events("reset_no_pulse");
    send(8'h12, BIT, 1'b1); expect_frame(8'h12, 1'b1);
    idle(40);
    check_events("after_reset");

    // Randomized frames: random data, bit period within +/-3 %, occasional
    // bad stop bit, random idle gaps (zero allowed after a good stop bit).
    for (int n = 0; n < 10; n++) begin
      logic [7:0] b;
      logic       sv;
      int         bc;
      int         gap;
      b   = 8'($urandom_range(0, 255));
      sv  = ($urandom_range(0, 4) != 0);
      bc  = $urandom_range(BIT - 2, BIT + 2);
      gap = sv ? $urandom_range(0, 30) : $urandom_range(4, 30);
      send(b, bc, sv);
      expect_frame(b, sv);
      if (gap > 0) idle(gap);
    end
    idle(40);
    check_events("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
